// File: rtl/bus_arb_pkg.sv
// Shared types and helpers for the round-robin / fixed-priority bus arbiter.
package bus_arb_pkg;

    localparam int MAX_MASTERS = 16;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        GRANT   = 3'd1,
        STROBE  = 3'd2,
        RELEASE = 3'd3,
        ERROR   = 3'd4
    } arb_state_t;

    // Index of the set bit; callers guarantee the vector is one-hot or zero.
    function automatic logic [3:0] onehot_to_idx(input logic [MAX_MASTERS-1:0] onehot);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 0; i < MAX_MASTERS; i++) begin
            idx = idx | (onehot[i] ? 4'(i) : 4'd0);
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational winner selection: rotating scan from ptr, or lowest index in fixed mode.
module rr_pick #(
    parameter int NUM_MASTERS = 4,
    parameter int ROUND_ROBIN = 1,
    localparam int IDX_W = $clog2(NUM_MASTERS)
) (
    input  logic [NUM_MASTERS-1:0] req,
    input  logic [IDX_W-1:0]       ptr,
    output logic [IDX_W-1:0]       winner,
    output logic                   valid
);

    int base_s;
    int idx_s;

    // First requesting master found when scanning upward from the base, wrapping.
    always_comb begin
        winner = {IDX_W{1'b0}};
        valid  = 1'b0;
        idx_s  = 32'sd0;
        base_s = (ROUND_ROBIN != 0) ? int'(ptr) : 32'sd0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            idx_s = (base_s + i) % NUM_MASTERS;
            if (!valid && req[idx_s]) begin
                winner = IDX_W'(idx_s);
                valid  = 1'b1;
            end else begin
                valid  = valid;
            end
        end
    end

endmodule

// File: rtl/bus_arbiter_rr.sv
// N-master bus arbiter with address-phase timeout and a one-cycle data strobe.
module bus_arbiter_rr
    import bus_arb_pkg::*;
#(
    parameter int NUM_MASTERS     = 4,
    parameter int CLK_MAX_TIMEOUT = 10,
    parameter int ROUND_ROBIN     = 1,
    localparam int IDX_W = $clog2(NUM_MASTERS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_MASTERS-1:0] barq_i,
    output logic [NUM_MASTERS-1:0] bagd_o,
    output logic [IDX_W-1:0]       grant_idx_o,
    output logic                   target_ready_o,
    input  logic                   address_valid_i,
    output logic                   data_strobe_o,
    output logic                   error_o,
    output logic [IDX_W-1:0]       err_idx_o,
    output logic                   busy_o
);

    localparam int TMR_W = $clog2(CLK_MAX_TIMEOUT) + 1;

    arb_state_t             state_r, nxt_state_s;
    logic [IDX_W-1:0]       ptr_r, nxt_ptr_s;
    logic [TMR_W-1:0]       timer_r, nxt_timer_s;
    logic [NUM_MASTERS-1:0] bagd_r, nxt_bagd_s;
    logic [IDX_W-1:0]       gidx_r, nxt_gidx_s;
    logic [IDX_W-1:0]       err_idx_r, nxt_err_idx_s;
    logic                   tr_r, nxt_tr_s;
    logic                   strobe_r, nxt_strobe_s;
    logic                   err_r, nxt_err_s;
    logic                   busy_r;
    logic [IDX_W-1:0]       pick_idx_s;
    logic                   pick_valid_s;
    logic [IDX_W-1:0]       ptr_after_s;

    rr_pick #(
        .NUM_MASTERS (NUM_MASTERS),
        .ROUND_ROBIN (ROUND_ROBIN)
    ) u_pick (
        .req    (barq_i),
        .ptr    (ptr_r),
        .winner (pick_idx_s),
        .valid  (pick_valid_s)
    );

    // Pointer value used whenever a grant ends; frozen in fixed-priority mode.
    always_comb begin
        if (ROUND_ROBIN == 0) begin
            ptr_after_s = ptr_r;
        end else if (gidx_r == IDX_W'(NUM_MASTERS - 1)) begin
            ptr_after_s = {IDX_W{1'b0}};
        end else begin
            ptr_after_s = gidx_r + IDX_W'(1);
        end
    end

    // Next state and next values of every registered output.
    always_comb begin
        nxt_state_s   = state_r;
        nxt_ptr_s     = ptr_r;
        nxt_timer_s   = timer_r;
        nxt_bagd_s    = bagd_r;
        nxt_gidx_s    = gidx_r;
        nxt_tr_s      = tr_r;
        nxt_strobe_s  = 1'b0;
        nxt_err_s     = 1'b0;
        nxt_err_idx_s = err_idx_r;
        case (state_r)
            IDLE: begin
                if (pick_valid_s) begin
                    nxt_state_s = GRANT;
                    nxt_gidx_s  = pick_idx_s;
                    nxt_bagd_s  = {{(NUM_MASTERS-1){1'b0}}, 1'b1} << pick_idx_s;
                    nxt_tr_s    = 1'b1;
                    nxt_timer_s = {TMR_W{1'b0}};
                end else begin
                    nxt_bagd_s  = {NUM_MASTERS{1'b0}};
                    nxt_tr_s    = 1'b0;
                end
            end
            GRANT: begin
                // Saturating so a long wait can never alias back to a small count.
                nxt_timer_s = (timer_r != {TMR_W{1'b1}}) ? timer_r + TMR_W'(1) : timer_r;
                if (!barq_i[gidx_r]) begin
                    nxt_state_s = IDLE;
                    nxt_bagd_s  = {NUM_MASTERS{1'b0}};
                    nxt_tr_s    = 1'b0;
                    nxt_ptr_s   = ptr_after_s;
                end else if (address_valid_i) begin
                    nxt_state_s  = STROBE;
                    nxt_strobe_s = 1'b1;
                end else if (timer_r == TMR_W'(CLK_MAX_TIMEOUT - 1)) begin
                    nxt_state_s   = ERROR;
                    nxt_err_s     = 1'b1;
                    nxt_err_idx_s = IDX_W'(onehot_to_idx(MAX_MASTERS'(bagd_r)));
                    nxt_bagd_s    = {NUM_MASTERS{1'b0}};
                    nxt_tr_s      = 1'b0;
                end else begin
                    nxt_state_s = GRANT;
                end
            end
            STROBE: begin
                nxt_state_s = RELEASE;
            end
            RELEASE: begin
                if (!barq_i[gidx_r]) begin
                    nxt_state_s = IDLE;
                    nxt_bagd_s  = {NUM_MASTERS{1'b0}};
                    nxt_tr_s    = 1'b0;
                    nxt_ptr_s   = ptr_after_s;
                end else begin
                    nxt_state_s = RELEASE;
                end
            end
            ERROR: begin
                nxt_state_s = IDLE;
                nxt_ptr_s   = ptr_after_s;
            end
            default: begin
                nxt_state_s = IDLE;
                nxt_bagd_s  = {NUM_MASTERS{1'b0}};
                nxt_tr_s    = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= IDLE;
            ptr_r     <= {IDX_W{1'b0}};
            timer_r   <= {TMR_W{1'b0}};
            bagd_r    <= {NUM_MASTERS{1'b0}};
            gidx_r    <= {IDX_W{1'b0}};
            err_idx_r <= {IDX_W{1'b0}};
            tr_r      <= 1'b0;
            strobe_r  <= 1'b0;
            err_r     <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            state_r   <= nxt_state_s;
            ptr_r     <= nxt_ptr_s;
            timer_r   <= nxt_timer_s;
            bagd_r    <= nxt_bagd_s;
            gidx_r    <= nxt_gidx_s;
            err_idx_r <= nxt_err_idx_s;
            tr_r      <= nxt_tr_s;
            strobe_r  <= nxt_strobe_s;
            err_r     <= nxt_err_s;
            busy_r    <= (nxt_state_s != IDLE);
        end
    end

    assign bagd_o         = bagd_r;
    assign grant_idx_o    = gidx_r;
    assign target_ready_o = tr_r;
    assign data_strobe_o  = strobe_r;
    assign error_o        = err_r;
    assign err_idx_o      = err_idx_r;
    assign busy_o         = busy_r;

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Directed-vector bench for bus_arbiter_rr: one round-robin and one fixed-priority instance.
module tb_bus_arbiter_rr;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] barq = 4'b0000;
    logic       av = 1'b0;
    logic [3:0] barq_fp = 4'b0000;
    logic       av_fp = 1'b0;

    logic [3:0] bagd, bagd_fp;
    logic [1:0] gidx, gidx_fp, eidx, eidx_fp;
    logic       tr, tr_fp, strobe, strobe_fp, err, err_fp, busy, busy_fp;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bus_arbiter_rr #(.NUM_MASTERS(4), .CLK_MAX_TIMEOUT(10), .ROUND_ROBIN(1)) dut (
        .clk(clk), .rst(rst), .barq_i(barq), .bagd_o(bagd), .grant_idx_o(gidx),
        .target_ready_o(tr), .address_valid_i(av), .data_strobe_o(strobe),
        .error_o(err), .err_idx_o(eidx), .busy_o(busy)
    );

    bus_arbiter_rr #(.NUM_MASTERS(4), .CLK_MAX_TIMEOUT(10), .ROUND_ROBIN(0)) dut_fp (
        .clk(clk), .rst(rst), .barq_i(barq_fp), .bagd_o(bagd_fp), .grant_idx_o(gidx_fp),
        .target_ready_o(tr_fp), .address_valid_i(av_fp), .data_strobe_o(strobe_fp),
        .error_o(err_fp), .err_idx_o(eidx_fp), .busy_o(busy_fp)
    );

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] one_k;
        logic       prev_strobe;

        // Reset state
        #12;
        check_val("rst_bagd", 32'(bagd), 32'h0);
        check_val("rst_gidx", 32'(gidx), 32'h0);
        check_val("rst_tr", 32'(tr), 32'h0);
        check_val("rst_strobe", 32'(strobe), 32'h0);
        check_val("rst_err", 32'(err), 32'h0);
        check_val("rst_eidx", 32'(eidx), 32'h0);
        check_val("rst_busy", 32'(busy), 32'h0);
        rst = 1'b0;
        tick();

        // Basic transaction, master 1
        barq = 4'b1010;
        tick();
        check_val("t1_bagd", 32'(bagd), 32'h2);
        check_val("t1_gidx", 32'(gidx), 32'h1);
        check_val("t1_tr", 32'(tr), 32'h1);
        check_val("t1_busy", 32'(busy), 32'h1);
        tick();
        check_val("t1_nostrobe", 32'(strobe), 32'h0);
        tick();
        av = 1'b1;
        tick();
        av = 1'b0;
        check_val("t1_strobe", 32'(strobe), 32'h1);
        tick();
        check_val("t1_strobe_end", 32'(strobe), 32'h0);
        check_val("t1_hold", 32'(bagd), 32'h2);
        barq = 4'b1000;
        tick();
        check_val("t1_release", 32'(bagd), 32'h0);
        check_val("t1_rel_tr", 32'(tr), 32'h0);
        check_val("t1_rel_busy", 32'(busy), 32'h0);
        barq = 4'b0000;

        // Fairness: round-robin vs fixed priority, all four requesting
        rst = 1'b1;
        #1;
        rst = 1'b0;
        barq = 4'b1111;
        barq_fp = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            one_k = 4'b0001 << k;
            tick();
            check_val("rr_grant", 32'(bagd), 32'(one_k));
            check_val("fp_grant", 32'(bagd_fp), 32'h1);
            av = 1'b1;
            av_fp = 1'b1;
            tick();
            av = 1'b0;
            av_fp = 1'b0;
            check_val("rr_strobe", 32'(strobe), 32'h1);
            check_val("fp_strobe", 32'(strobe_fp), 32'h1);
            tick();
            check_val("rr_strobe_once", 32'(strobe), 32'h0);
            check_val("fp_strobe_once", 32'(strobe_fp), 32'h0);
            barq = 4'b1111 & ~one_k;
            barq_fp = 4'b1110;
            tick();
            check_val("rr_drop", 32'(bagd), 32'h0);
            check_val("fp_drop", 32'(bagd_fp), 32'h0);
            barq = 4'b1111;
            barq_fp = 4'b1111;
        end
        barq_fp = 4'b0000;

        // Timeout on master 2; master 3 also waiting
        barq = 4'b1100;
        tick();
        check_val("to_grant", 32'(bagd), 32'h4);
        for (int c = 1; c < 10; c++) begin
            tick();
            check_val("to_wait_err", 32'(err), 32'h0);
            check_val("to_wait_gnt", 32'(bagd), 32'h4);
        end
        tick();
        check_val("to_err", 32'(err), 32'h1);
        check_val("to_eidx", 32'(eidx), 32'h2);
        check_val("to_bagd", 32'(bagd), 32'h0);
        check_val("to_tr", 32'(tr), 32'h0);
        check_val("to_strobe", 32'(strobe), 32'h0);
        tick();
        check_val("to_err_pulse", 32'(err), 32'h0);
        check_val("to_eidx_hold", 32'(eidx), 32'h2);
        tick();
        check_val("to_next_grant", 32'(bagd), 32'h8);
        barq = 4'b0000;
        tick();
        check_val("to_next_abort", 32'(bagd), 32'h0);

        // Abort of master 0 at grant+3
        barq = 4'b0001;
        tick();
        check_val("ab_grant", 32'(bagd), 32'h1);
        tick();
        tick();
        tick();
        barq = 4'b0000;
        tick();
        check_val("ab_bagd", 32'(bagd), 32'h0);
        check_val("ab_err", 32'(err), 32'h0);
        check_val("ab_strobe", 32'(strobe), 32'h0);
        check_val("ab_busy", 32'(busy), 32'h0);
        barq = 4'b1111;
        tick();
        check_val("ab_ptr", 32'(bagd), 32'h2);

        // Reset while the strobe is high
        av = 1'b1;
        tick();
        av = 1'b0;
        check_val("rs_strobe", 32'(strobe), 32'h1);
        rst = 1'b1;
        #1;
        check_val("rs_bagd", 32'(bagd), 32'h0);
        check_val("rs_strobe0", 32'(strobe), 32'h0);
        check_val("rs_tr", 32'(tr), 32'h0);
        check_val("rs_busy", 32'(busy), 32'h0);
        rst = 1'b0;
        barq = 4'b1000;
        tick();
        check_val("rs_regrant", 32'(bagd), 32'h8);
        barq = 4'b0000;
        tick();

        // Random traffic with invariant checks
        prev_strobe = 1'b0;
        for (int n = 0; n < 300; n++) begin
            barq = 4'($urandom_range(0, 15));
            av = 1'($urandom_range(0, 1));
            tick();
            check_val("inv_onehot", 32'($onehot0(bagd)), 32'h1);
            check_val("inv_strobe2", 32'(prev_strobe & strobe), 32'h0);
            check_val("inv_tr", 32'(tr), 32'(|bagd));
            prev_strobe = strobe;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
